scan_reg_bank: RTL and testbench

Parametrised state-register bank that replaces the single-bit `dff` primitive in the sequential benchmark netlists. It holds WIDTH state bits, reset asynchronously to a programmable value, and supports hold, parallel capture, serial scan shift and MISR signature compaction. An autonomous WIDTH-cycle unload sequencer lets the test controller read the complete state through SO with a single START pulse.

---
 rtl/scan_reg_bank.sv | 94 +++++++++
 tb/tb_scan_reg_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_reg_bank.sv
// Purpose : WIDTH-bit state register bank with hold, capture, scan shift, MISR and auto-unload.
// Latency : every mode takes effect at the first rising CK edge; SO is combinational from Q.
// Backpr. : none; START and MODE are ignored while BUSY, and no unload request is queued.
//
// Ports:
//   CK, RST      clock; asynchronous active-high reset
//   MODE[1:0]    00 hold, 01 capture D, 10 shift SI in, 11 MISR compaction of D
//   D[WIDTH]     parallel / response data from the combinational core
//   SI           scan serial input
//   START        request a WIDTH-cycle unload through SO (takes priority over MODE)
//   Q[WIDTH]     register contents
//   SO           scan serial output, always Q[WIDTH-1]
//   BUSY         unload in progress
//   DONE         one-cycle pulse on the edge that completes an unload
module scan_reg_bank #(
    parameter int                 WIDTH     = 19,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0]   MISR_POLY = {{(WIDTH-2){1'b0}}, 2'b11}
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    input  logic             START,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] shift_val;
    logic [WIDTH-1:0] misr_val;

    // Shift and MISR next values are shared between the IDLE modes and the unload.
    assign shift_val = {Q[WIDTH-2:0], SI};
    assign misr_val  = {Q[WIDTH-2:0], 1'b0} ^ (Q[WIDTH-1] ? MISR_POLY : {WIDTH{1'b0}}) ^ D;

    assign SO = Q[WIDTH-1];

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            Q     <= RESET_VAL;
            state <= IDLE;
            cnt   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        // Q holds on the start edge; shifting begins on the next edge.
                        state <= SHIFT;
                        cnt   <= CNT_LOAD;
                        BUSY  <= 1'b1;
                    end else begin
                        case (MODE)
                            2'b01:   Q <= D;
                            2'b10:   Q <= shift_val;
                            2'b11:   Q <= misr_val;
                            default: Q <= Q;
                        endcase
                    end
                end
                SHIFT: begin
                    Q   <= shift_val;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_reg_bank.sv
// Purpose : self-checking bench for scan_reg_bank (WIDTH=4, RESET_VAL=1010, POLY=0011).
// Latency : reference model advances once per rising edge; outputs sampled 1 time unit later.
// Backpr. : not applicable; stimulus is directed scenarios followed by random cycles.
module tb_scan_reg_bank;

    localparam int W    = 4;
    localparam int RVAL = 10;   // 4'b1010
    localparam int POLY = 3;    // 4'b0011

    logic         CK;
    logic         RST;
    logic [1:0]   MODE;
    logic [W-1:0] D;
    logic         SI;
    logic         START;
    logic [W-1:0] Q;
    logic         SO;
    logic         BUSY;
    logic         DONE;

    int total = 0;
    int bad   = 0;

    // Reference model: register value as an integer, unload as a count of shifts left.
    int mq;
    int rem;
    int mdone;

    scan_reg_bank #(
        .WIDTH     (W),
        .RESET_VAL (4'b1010),
        .MISR_POLY (4'b0011)
    ) dut (
        .CK    (CK),
        .RST   (RST),
        .MODE  (MODE),
        .D     (D),
        .SI    (SI),
        .START (START),
        .Q     (Q),
        .SO    (SO),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_q"},    32'(Q),    32'(mq));
        chk({tag, "_so"},   32'(SO),   32'(mq / 8));
        chk({tag, "_busy"}, 32'(BUSY), 32'(rem > 0));
        chk({tag, "_done"}, 32'(DONE), 32'(mdone));
    endtask

    // Drive one cycle's inputs, take the edge, advance the model, compare.
    task automatic step(input logic [1:0] m, input logic [3:0] d, input logic si, input logic st);
        MODE  = m;
        D     = d;
        SI    = si;
        START = st;
        @(posedge CK);
        if (rem > 0) begin
            mq    = (mq * 2 + int'(si)) % 16;
            rem   = rem - 1;
            mdone = (rem == 0);
        end else begin
            mdone = 0;
            if (st) begin
                rem = W;
            end else if (m == 2'd1) begin
                mq = int'(d);
            end else if (m == 2'd2) begin
                mq = (mq * 2 + int'(si)) % 16;
            end else if (m == 2'd3) begin
                mq = ((mq * 2) % 16) ^ ((mq >= 8) ? POLY : 0) ^ int'(d);
            end
        end
        #1;
        chk_all("step");
    endtask

    // Mid-cycle reset pulse, checked before any edge arrives.
    task automatic rst_pulse();
        #2;
        RST = 1'b1;
        mq    = RVAL;
        rem   = 0;
        mdone = 0;
        #1;
        chk("rst_q",    32'(Q),    32'(RVAL));
        chk("rst_so",   32'(SO),   32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        #1;
        RST = 1'b0;
    endtask

    logic [3:0] so_exp;
    logic [3:0] si_seq;
    logic [3:0] misr_d;
    logic [3:0] misr_q [5];
    int         busy_cnt;
    int         done_cnt;

    initial begin
        RST   = 1'b0;
        MODE  = 2'b00;
        D     = '0;
        SI    = 1'b0;
        START = 1'b0;
        mq    = RVAL;
        rem   = 0;
        mdone = 0;
        @(posedge CK);
        #1;
        rst_pulse();

        // Hold after reset.
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 4'hF, 1'b1, 1'b0);
            chk("hold_rst", 32'(Q), 32'hA);
        end

        // Capture, shift, hold.
        step(2'b01, 4'b0110, 1'b0, 1'b0);
        chk("capture", 32'(Q), 32'b0110);
        step(2'b10, 4'b0000, 1'b1, 1'b0);
        chk("shift", 32'(Q), 32'b1101);
        step(2'b00, 4'b0000, 1'b0, 1'b0);
        chk("hold", 32'(Q), 32'b1101);

        // Unload of 1011; START with MODE=01 must not capture; re-START while busy ignored.
        step(2'b01, 4'b1011, 1'b0, 1'b0);
        step(2'b01, 4'b0101, 1'b0, 1'b1);
        chk("start_prio_q", 32'(Q), 32'b1011);
        so_exp   = 4'b1011;
        si_seq   = 4'b1100;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            chk("unload_so", 32'(SO), 32'(so_exp[3-i]));
            busy_cnt += int'(BUSY);
            step(2'b01, 4'($urandom), si_seq[3-i], i == 1);
            done_cnt += int'(DONE);
        end
        chk("unload_q", 32'(Q), 32'b1100);
        chk("unload_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("unload_busy_end", 32'(BUSY), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(2'b00, 4'h0, 1'b0, 1'b0);
            done_cnt += int'(DONE);
        end
        chk("unload_done_once", 32'(done_cnt), 32'd1);

        // MISR compaction from zero.
        step(2'b01, 4'b0000, 1'b0, 1'b0);
        misr_d = 4'b0001;
        misr_q[0] = 4'b0001;
        misr_q[1] = 4'b0010;
        misr_q[2] = 4'b0100;
        misr_q[3] = 4'b1000;
        misr_q[4] = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            step(2'b11, (i == 0) ? misr_d : 4'b0000, 1'b0, 1'b0);
            chk("misr", 32'(Q), 32'(misr_q[i]));
        end

        // Abort an unload with reset after two shift edges.
        step(2'b00, 4'h0, 1'b1, 1'b1);
        step(2'b00, 4'h0, 1'b1, 1'b0);
        step(2'b00, 4'h0, 1'b1, 1'b0);
        rst_pulse();
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(2'b00, 4'h0, 1'b0, 1'b0);
            done_cnt += int'(DONE);
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_q", 32'(Q), 32'hA);

        // START held high: back-to-back unloads W+1 edges apart.
        done_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            step(2'b00, 4'h0, 1'($urandom), 1'b1);
            done_cnt += int'(DONE);
        end
        chk("start_held_dones", 32'(done_cnt), 32'd2);
        step(2'b00, 4'h0, 1'b0, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                rst_pulse();
            end
            step(2'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
